seq_datapath: RTL



---
 rtl/seq_datapath.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/seq_datapath.sv
// Self-sequencing single-bus datapath: ALU, signed multiply into HI/LO, MAR/MDR memory load, HI/LO moves.
// Latency (start edge = e0, done high the cycle after): illegal e1, MFHI/MFLO e2, ALU e3, MUL e4, LOAD e3 + wait cycles.
// Backpressure: start is only sampled in IDLE (ignored while busy); the MEM state waits on mem_ready up to MEM_TIMEOUT cycles.
module seq_datapath #(
  parameter int WIDTH       = 32,
  parameter int NREGS       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter int RW          = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [RW-1:0]    ra,
  input  logic [RW-1:0]    rb,
  input  logic [RW-1:0]    rc,
  input  logic [WIDTH-1:0] mem_data_in,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic [WIDTH-1:0] mem_addr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] zlow_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHRA = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_LOAD = 4'd9;
  localparam logic [3:0] OP_MFHI = 4'd10;
  localparam logic [3:0] OP_MFLO = 4'd11;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4, MEM, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [RW-1:0]           ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [WIDTH-1:0]        regs_q [NREGS];
  logic [WIDTH-1:0]        regs_d [NREGS];
  logic [WIDTH-1:0]        y_q, y_d, zhi_q, zhi_d, zlo_q, zlo_d;
  logic [WIDTH-1:0]        mar_q, mar_d, mdr_q, mdr_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic [WIDTH-1:0]        bus;
  logic [WIDTH-1:0]        alu_res;
  logic [WIDTH-1:0]        wr_dat;
  logic [SW-1:0]           shamt;
  logic signed [2*WIDTH-1:0] prod;

  // Control-step sequencer: next state, bus source and every register's next value.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    regs_d  = regs_q;
    y_d     = y_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bus     = '0;
    alu_res = '0;
    wr_dat  = '0;
    shamt   = '0;
    prod    = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = opcode;
          ra_d    = ra;
          rb_d    = rb;
          rc_d    = rc;
          err_d   = 1'b0;
          state_d = T1;
        end
      end
      // Opcode is decoded here, so every instruction (even an illegal one) spends one cycle in T1.
      T1: begin
        bus = regs_q[rb_q];
        if (op_q == OP_LOAD) begin
          mar_d   = bus;
          cnt_d   = '0;
          state_d = MEM;
        end else if (op_q == OP_MFHI || op_q == OP_MFLO) begin
          state_d = T3;
        end else if (op_q > OP_MFLO) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          y_d     = bus;
          state_d = T2;
        end
      end
      T2: begin
        bus   = regs_q[rc_q];
        shamt = bus[SW-1:0];
        prod  = $signed(y_q) * $signed(bus);
        case (op_q)
          OP_ADD:  alu_res = y_q + bus;
          OP_SUB:  alu_res = y_q - bus;
          OP_AND:  alu_res = y_q & bus;
          OP_OR:   alu_res = y_q | bus;
          OP_SHL:  alu_res = y_q << shamt;
          OP_SHR:  alu_res = y_q >> shamt;
          OP_SHRA: alu_res = $unsigned($signed(y_q) >>> shamt);
          OP_NOT:  alu_res = ~y_q;
          default: alu_res = '0;
        endcase
        if (op_q == OP_MUL) begin
          {zhi_d, zlo_d} = prod;
        end else begin
          zhi_d = '0;
          zlo_d = alu_res;
        end
        state_d = T3;
      end
      T3: begin
        if (op_q == OP_MUL) begin
          lo_d    = zlo_q;
          state_d = T4;
        end else begin
          case (op_q)
            OP_LOAD: wr_dat = mdr_q;
            OP_MFHI: wr_dat = hi_q;
            OP_MFLO: wr_dat = lo_q;
            default: wr_dat = zlo_q;
          endcase
          bus = wr_dat;
          // R0 is hard-wired to zero, so its write is simply dropped.
          if (ra_q != '0) regs_d[ra_q] = bus;
          state_d = DONE;
        end
      end
      T4: begin
        hi_d    = zhi_q;
        state_d = DONE;
      end
      MEM: begin
        if (mem_ready) begin
          mdr_d   = mem_data_in;
          cnt_d   = '0;
          state_d = T3;
        end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; clr clears everything and beats a simultaneous start.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      y_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      regs_q  <= regs_d;
      y_q     <= y_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Status and register views.
  always_comb begin
    mem_read = (state_q == MEM);
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    err      = (state_q == DONE) && err_q;
    mem_addr = mar_q;
    zlow_out = zlo_q;
    hi_out   = hi_q;
    lo_out   = lo_q;
    dbg_data = (dbg_sel == '0) ? '0 : regs_q[dbg_sel];
  end

endmodule
